// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RISC-V core: per-stage stall/flush,
// PC redirect, divider and data-memory wait sequencing, memory watchdog and perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic [31:0]      branch_target_ex,
    input  logic             div_start_ex,
    input  logic             div_done,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready_mem,
    input  logic             imem_ready,

    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        StRun,
        StDivWait
    } state_e;

    typedef enum logic [2:0] {
        HzNone,
        HzMemFreeze,
        HzDivBusy,
        HzRedirect,
        HzLoadUse,
        HzFetchWait
    } hazard_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic    mem_freeze;
    logic    div_busy;
    logic    load_use;
    hazard_e hazard;

    assign mem_freeze = dmem_req_mem && !dmem_ready_mem;

    // The divider stalls from its start cycle; the div_done cycle itself lets EX_MEM capture.
    assign div_busy = ((state_q == StDivWait) && !div_done) ||
                      ((state_q == StRun) && div_start_ex && !div_done);

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    always_comb begin
        hazard = HzNone;
        if (mem_freeze) begin
            hazard = HzMemFreeze;
        end else if (div_busy) begin
            hazard = HzDivBusy;
        end else if (branch_taken_ex) begin
            hazard = HzRedirect;
        end else if (load_use) begin
            hazard = HzLoadUse;
        end else if (!imem_ready) begin
            hazard = HzFetchWait;
        end
    end

    // Only the winning hazard drives the pipeline; everything is forced quiet during reset.
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_flush   = 1'b0;
        redirect_valid = 1'b0;
        if (rst_n) begin
            unique case (hazard)
                HzMemFreeze: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end
                HzDivBusy: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                HzRedirect: begin
                    redirect_valid = 1'b1;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                end
                HzLoadUse: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HzFetchWait: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                end
                HzNone: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign redirect_pc = branch_target_ex;

    // A freeze holds the divider sequencing; a div_done seen under freeze is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (div_start_ex && !div_done && !mem_freeze) begin
                    state_d = StDivWait;
                end
            end
            StDivWait: begin
                if (div_done && !mem_freeze) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (mem_freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(pc_stall);
        flush_count_d  = flush_count_q + CNT_W'(redirect_valid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a table-driven priority model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        div_start_ex, div_done, dmem_req_mem, dmem_ready_mem, imem_ready;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        redirect_valid, mem_timeout;
    logic [31:0] redirect_pc, stall_cycles, flush_count;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .rs1_used_id      (rs1_used_id),
        .rs2_used_id      (rs2_used_id),
        .rd_ex            (rd_ex),
        .mem_read_ex      (mem_read_ex),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .div_start_ex     (div_start_ex),
        .div_done         (div_done),
        .dmem_req_mem     (dmem_req_mem),
        .dmem_ready_mem   (dmem_ready_mem),
        .imem_ready       (imem_ready),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .id_ex_stall      (id_ex_stall),
        .ex_mem_stall     (ex_mem_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_flush     (mem_wb_flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mem_timeout      (mem_timeout),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, redirect_valid}
    localparam logic [8:0] V_NONE   = 9'b0000_0000_0;
    localparam logic [8:0] V_FREEZE = 9'b1111_0001_0;
    localparam logic [8:0] V_DIV    = 9'b1110_0010_0;
    localparam logic [8:0] V_REDIR  = 9'b0000_1100_1;
    localparam logic [8:0] V_LDUSE  = 9'b1100_0100_0;
    localparam logic [8:0] V_FETCH  = 9'b1000_1000_0;

    function automatic logic [8:0] ctrl_for(int cause);
        case (cause)
            1:       return V_FREEZE;
            2:       return V_DIV;
            3:       return V_REDIR;
            4:       return V_LDUSE;
            5:       return V_FETCH;
            default: return V_NONE;
        endcase
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, redirect_valid};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model state: divider in flight, freeze run length, sticky flag, counters.
    bit          m_in_div = 0, m_in_div_n = 0;
    int          m_wait = 0, m_wait_n = 0;
    bit          m_tmo = 0, m_tmo_n = 0;
    logic [31:0] m_stalls = 0, m_stalls_n = 0;
    logic [31:0] m_flushes = 0, m_flushes_n = 0;

    always @(negedge clk) begin : model_cmp
        bit         freeze, busy, lu;
        int         cause;
        logic [8:0] exp_ctrl;
        freeze = dmem_req_mem && !dmem_ready_mem;
        busy   = m_in_div ? !div_done : (div_start_ex && !div_done);
        lu     = mem_read_ex && (rd_ex != 0) &&
                 ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        if (!rst_n)               cause = 0;
        else if (freeze)          cause = 1;
        else if (busy)            cause = 2;
        else if (branch_taken_ex) cause = 3;
        else if (lu)              cause = 4;
        else if (!imem_ready)     cause = 5;
        else                      cause = 0;
        exp_ctrl = ctrl_for(cause);
        if (chk_en) begin
            check("ctrl", dut_ctrl(), exp_ctrl);
            check("redirect_pc", redirect_pc, branch_target_ex);
            check("mem_timeout", mem_timeout, m_tmo);
            check("stall_cycles", stall_cycles, m_stalls);
            check("flush_count", flush_count, m_flushes);
        end
        if (!rst_n) begin
            m_in_div_n = 0; m_wait_n = 0; m_tmo_n = 0; m_stalls_n = 0; m_flushes_n = 0;
        end else begin
            m_in_div_n  = freeze ? m_in_div : busy;
            m_wait_n    = freeze ? ((m_wait + 1 > int'(MT) - 1) ? int'(MT) - 1 : m_wait + 1) : 0;
            m_tmo_n     = m_tmo || (freeze && m_wait == int'(MT) - 1);
            m_stalls_n  = m_stalls + 32'(exp_ctrl[8]);
            m_flushes_n = m_flushes + 32'(exp_ctrl[0]);
        end
    end

    always @(posedge clk) begin
        m_in_div  <= m_in_div_n;
        m_wait    <= m_wait_n;
        m_tmo     <= m_tmo_n;
        m_stalls  <= m_stalls_n;
        m_flushes <= m_flushes_n;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_id = 0; rs2_id = 0; rd_ex = 0;
        rs1_used_id = 0; rs2_used_id = 0; mem_read_ex = 0;
        branch_taken_ex = 0; branch_target_ex = 32'h0000_0100;
        div_start_ex = 0; div_done = 0;
        dmem_req_mem = 0; dmem_ready_mem = 1; imem_ready = 1;
    endtask

    initial begin
        rst_n = 0;
        clr();
        cyc();
        chk_en = 1;
        cyc();
        rst_n = 1;
        @(negedge clk);
        check("reset ctrl", dut_ctrl(), V_NONE);
        check("reset stall_cycles", stall_cycles, 0);
        check("reset flush_count", flush_count, 0);
        check("reset mem_timeout", mem_timeout, 0);

        // Load-use for one cycle, then rd_ex=0 gives no stall.
        cyc();
        mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
        @(negedge clk);
        check("load-use ctrl", dut_ctrl(), V_LDUSE);
        cyc();
        rd_ex = 0;
        @(negedge clk);
        check("load-use rd0 ctrl", dut_ctrl(), V_NONE);
        check("load-use stall_cycles", stall_cycles, 1);

        // Taken branch to 0x200.
        cyc();
        clr();
        branch_taken_ex = 1; branch_target_ex = 32'h0000_0200;
        @(negedge clk);
        check("branch ctrl", dut_ctrl(), V_REDIR);
        check("branch redirect_pc", redirect_pc, 32'h200);
        check("branch flush_count before", flush_count, 0);
        cyc();
        clr();
        @(negedge clk);
        check("branch flush_count after", flush_count, 1);

        // Divide: start in cycle 0, done in cycle 33.
        cyc();
        div_start_ex = 1;
        @(negedge clk);
        check("div cycle0 ctrl", dut_ctrl(), V_DIV);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            div_start_ex = 0;
            @(negedge clk);
            check("div wait ctrl", dut_ctrl(), V_DIV);
        end
        cyc();
        div_done = 1;
        @(negedge clk);
        check("div done ctrl", dut_ctrl(), V_NONE);
        cyc();
        div_done = 0;
        @(negedge clk);
        check("div back to run", dut_ctrl(), V_NONE);
        check("div stall_cycles", stall_cycles, 34);

        // Memory freeze for 6 cycles with MEM_TIMEOUT=4.
        for (int i = 0; i < 6; i++) begin
            cyc();
            dmem_req_mem = 1; dmem_ready_mem = 0;
            @(negedge clk);
            check("freeze ctrl", dut_ctrl(), V_FREEZE);
            check("freeze mem_timeout", mem_timeout, (i >= 4) ? 1 : 0);
        end
        cyc();
        dmem_ready_mem = 1;
        @(negedge clk);
        check("freeze end ctrl", dut_ctrl(), V_NONE);
        check("mem_timeout sticky", mem_timeout, 1);

        // Priority: freeze beats branch and load-use; branch then wins when unfrozen.
        cyc();
        clr();
        dmem_req_mem = 1; dmem_ready_mem = 0;
        branch_taken_ex = 1; branch_target_ex = 32'h0000_0344;
        mem_read_ex = 1; rd_ex = 7; rs2_id = 7; rs2_used_id = 1;
        @(negedge clk);
        check("priority freeze ctrl", dut_ctrl(), V_FREEZE);
        cyc();
        dmem_ready_mem = 1;
        @(negedge clk);
        check("priority redirect ctrl", dut_ctrl(), V_REDIR);

        // Reset during DIV_WAIT.
        cyc();
        clr();
        div_start_ex = 1;
        @(negedge clk);
        cyc();
        div_start_ex = 0;
        @(negedge clk);
        check("div_wait before reset", dut_ctrl(), V_DIV);
        cyc();
        rst_n = 0;
        @(negedge clk);
        check("in-reset ctrl", dut_ctrl(), V_NONE);
        cyc();
        rst_n = 1;
        @(negedge clk);
        check("post-reset ctrl", dut_ctrl(), V_NONE);
        check("post-reset stall_cycles", stall_cycles, 0);
        check("post-reset flush_count", flush_count, 0);
        check("post-reset mem_timeout", mem_timeout, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst_n            = ($urandom_range(0, 99) != 0);
            rs1_id           = 5'($urandom_range(0, 3));
            rs2_id           = 5'($urandom_range(0, 3));
            rd_ex            = 5'($urandom_range(0, 3));
            rs1_used_id      = 1'($urandom);
            rs2_used_id      = 1'($urandom);
            mem_read_ex      = 1'($urandom);
            branch_taken_ex  = ($urandom_range(0, 5) == 0);
            branch_target_ex = $urandom;
            div_start_ex     = ($urandom_range(0, 9) == 0);
            div_done         = ($urandom_range(0, 5) == 0);
            dmem_req_mem     = 1'($urandom);
            dmem_ready_mem   = (i % 200 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            imem_ready       = ($urandom_range(0, 4) != 0);
        end
        cyc();
        clr();
        rst_n = 1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
